// File: rtl/s2mm_write_scheduler_pkg.sv
// Shared definitions for the S2MM write scheduler: FSM states and the
// DataMover command/status field positions.
package s2mm_write_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        START,
        STREAM,
        STATUS,
        FINISH
    } state_t;

    localparam int BEATS_W = 26;
    localparam int TAG_W   = 4;
    localparam int CMD_W   = 72;
    localparam int STS_W   = 8;

    localparam int CMD_BTT_LSB   = 0;
    localparam int CMD_BTT_MSB   = 22;
    localparam int CMD_TYPE_BIT  = 23;
    localparam int CMD_EOF_BIT   = 30;
    localparam int CMD_SADDR_LSB = 32;
    localparam int CMD_SADDR_MSB = 63;
    localparam int CMD_TAG_LSB   = 64;
    localparam int CMD_TAG_MSB   = 67;

    localparam int STS_TAG_LSB    = 0;
    localparam int STS_TAG_MSB    = 3;
    localparam int STS_INTERR_BIT = 4;
    localparam int STS_DECERR_BIT = 5;
    localparam int STS_SLVERR_BIT = 6;
    localparam int STS_OKAY_BIT   = 7;

endpackage

// File: rtl/s2mm_write_scheduler.sv
// Splits a stream-to-memory job into DataMover S2MM bursts, starts the data
// generator per burst, watches the stream for tlast and checks each status.
//
// state  | meaning
// IDLE   | waiting for a job, job_ready high
// CMD    | presenting the DataMover command for the current burst
// START  | one-cycle gen_valid pulse with the burst length
// STREAM | counting generator beats until tlast
// STATUS | waiting for the DataMover status of the burst
// FINISH | one-cycle done pulse
module s2mm_write_scheduler
    import s2mm_write_scheduler_pkg::*;
#(
    parameter int DW        = 128,
    parameter int MAX_BEATS = 256,
    parameter int ADDR_W    = 32
) (
    input  logic                axis_clk,
    input  logic                axis_reset,
    input  logic                job_valid,
    output logic                job_ready,
    input  logic [ADDR_W-1:0]   job_addr,
    input  logic [BEATS_W-1:0]  job_beats,
    output logic                gen_valid,
    output logic [BEATS_W-1:0]  gen_length,
    input  logic                mon_tvalid,
    input  logic                mon_tready,
    input  logic                mon_tlast,
    output logic [CMD_W-1:0]    cmd_tdata,
    output logic                cmd_tvalid,
    input  logic                cmd_tready,
    input  logic [STS_W-1:0]    sts_tdata,
    input  logic                sts_tvalid,
    output logic                sts_tready,
    output logic                busy,
    output logic                done,
    output logic                error
);

    localparam int BPB = DW / 8;
    localparam logic [BEATS_W:0]   MAX_B        = MAX_BEATS[BEATS_W:0];
    localparam logic [BEATS_W:0]   MAX_P1       = MAX_B + 1'b1;
    localparam logic [BEATS_W-1:0] MAX_BURST    = MAX_B[BEATS_W-1:0];
    localparam logic [BEATS_W-1:0] MAX_BURST_M1 = MAX_BURST - 1'b1;

    state_t              state;
    state_t              state_n;
    logic [ADDR_W-1:0]   addr;
    logic [BEATS_W-1:0]  remaining;
    logic [TAG_W-1:0]    tag;
    logic [BEATS_W-1:0]  beat_cnt;
    logic [BEATS_W-1:0]  beat_next;
    logic [BEATS_W-1:0]  burst;
    logic [22:0]         btt;
    logic [ADDR_W-1:0]   step;
    logic [31:0]         saddr;
    logic                beat_hs;
    logic                sts_bad;
    logic                last_burst;

    // Exactly MAX+1 remaining would leave a 1-beat tail, so shave one beat
    // off this burst and finish with a 2-beat burst instead.
    always_comb begin
        if ({1'b0, remaining} > MAX_P1) begin
            burst = MAX_BURST;
        end else if ({1'b0, remaining} == MAX_P1) begin
            burst = MAX_BURST_M1;
        end else begin
            burst = remaining;
        end
    end

    assign btt        = 23'(burst * BPB);
    assign step       = ADDR_W'(btt);
    assign saddr      = 32'(addr);
    assign beat_hs    = mon_tvalid & mon_tready;
    assign beat_next  = beat_cnt + 1'b1;
    assign last_burst = (remaining == burst);
    assign sts_bad    = ~sts_tdata[STS_OKAY_BIT] | sts_tdata[STS_SLVERR_BIT] |
                        sts_tdata[STS_DECERR_BIT] | sts_tdata[STS_INTERR_BIT] |
                        (sts_tdata[STS_TAG_MSB:STS_TAG_LSB] != tag);

    always_ff @(posedge axis_clk) begin
        if (axis_reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        job_ready  = 1'b0;
        cmd_tvalid = 1'b0;
        gen_valid  = 1'b0;
        sts_tready = 1'b0;
        done       = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                job_ready = 1'b1;
                if (job_valid) begin
                    state_n = (job_beats >= 26'd2) ? CMD : FINISH;
                end
            end
            CMD: begin
                cmd_tvalid = 1'b1;
                if (cmd_tready) begin
                    state_n = START;
                end
            end
            START: begin
                gen_valid = 1'b1;
                state_n   = STREAM;
            end
            STREAM: begin
                if (beat_hs && mon_tlast) begin
                    state_n = STATUS;
                end
            end
            STATUS: begin
                sts_tready = 1'b1;
                if (sts_tvalid) begin
                    state_n = (error || sts_bad || last_burst) ? FINISH : CMD;
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        cmd_tdata = '0;
        if (state == CMD) begin
            cmd_tdata[CMD_BTT_MSB:CMD_BTT_LSB]     = btt;
            cmd_tdata[CMD_TYPE_BIT]                = 1'b1;
            cmd_tdata[CMD_EOF_BIT]                 = 1'b1;
            cmd_tdata[CMD_SADDR_MSB:CMD_SADDR_LSB] = saddr;
            cmd_tdata[CMD_TAG_MSB:CMD_TAG_LSB]     = tag;
        end
    end

    always_ff @(posedge axis_clk) begin
        if (axis_reset) begin
            addr       <= '0;
            remaining  <= '0;
            tag        <= '0;
            beat_cnt   <= '0;
            error      <= 1'b0;
            gen_length <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (job_valid) begin
                        addr      <= job_addr;
                        remaining <= job_beats;
                        error     <= (job_beats < 26'd2);
                    end
                end
                CMD: begin
                    if (cmd_tready) begin
                        gen_length <= burst;
                        beat_cnt   <= '0;
                    end
                end
                STREAM: begin
                    if (beat_hs) begin
                        beat_cnt <= beat_next;
                        if (mon_tlast && (beat_next != burst)) begin
                            error <= 1'b1;
                        end
                    end
                end
                STATUS: begin
                    if (sts_tvalid) begin
                        if (sts_bad) begin
                            error <= 1'b1;
                        end else if (!error && !last_burst) begin
                            addr      <= addr + step;
                            remaining <= remaining - burst;
                            tag       <= tag + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_s2mm_write_scheduler.sv
// Scoreboard bench: job tasks push expected commands, generator lengths and
// done/error outcomes; a negedge monitor pops and compares them.
module tb_s2mm_write_scheduler;

    logic         axis_clk = 1'b0;
    logic         axis_reset;
    logic         job_valid;
    logic         job_ready;
    logic [31:0]  job_addr;
    logic [25:0]  job_beats;
    logic         gen_valid;
    logic [25:0]  gen_length;
    logic         mon_tvalid;
    logic         mon_tready;
    logic         mon_tlast;
    logic [71:0]  cmd_tdata;
    logic         cmd_tvalid;
    logic         cmd_tready;
    logic [7:0]   sts_tdata;
    logic         sts_tvalid;
    logic         sts_tready;
    logic         busy;
    logic         done;
    logic         error;

    s2mm_write_scheduler #(.DW(128), .MAX_BEATS(256), .ADDR_W(32)) dut (
        .axis_clk   (axis_clk),
        .axis_reset (axis_reset),
        .job_valid  (job_valid),
        .job_ready  (job_ready),
        .job_addr   (job_addr),
        .job_beats  (job_beats),
        .gen_valid  (gen_valid),
        .gen_length (gen_length),
        .mon_tvalid (mon_tvalid),
        .mon_tready (mon_tready),
        .mon_tlast  (mon_tlast),
        .cmd_tdata  (cmd_tdata),
        .cmd_tvalid (cmd_tvalid),
        .cmd_tready (cmd_tready),
        .sts_tdata  (sts_tdata),
        .sts_tvalid (sts_tvalid),
        .sts_tready (sts_tready),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 axis_clk = ~axis_clk;

    int cmp_cnt  = 0;
    int mis_cnt  = 0;
    int cmd_seen = 0;
    int done_seen = 0;
    logic [3:0] model_tag = 4'd0;

    logic [71:0] exp_cmd[$];
    logic [25:0] exp_gen[$];
    logic        exp_done[$];

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        cmp_cnt++;
        mis_cnt++;
        $display("FAIL %s: event not as expected at %0t", name, $time);
    endtask

    function automatic logic [71:0] make_cmd(input logic [25:0] len, input logic [31:0] a,
                                              input logic [3:0] t);
        logic [22:0] b;
        b = 23'(len * 16);
        return {4'h0, t, a, 1'b0, 1'b1, 6'h00, 1'b1, b};
    endfunction

    always @(negedge axis_clk) begin
        if (!axis_reset) begin
            if (cmd_tvalid && cmd_tready) begin
                cmd_seen++;
                if (exp_cmd.size() == 0) flag("unexpected_cmd");
                else check("cmd_tdata", cmd_tdata, exp_cmd.pop_front());
            end
            if (gen_valid) begin
                if (exp_gen.size() == 0) flag("unexpected_gen");
                else check("gen_length", 72'(gen_length), 72'(exp_gen.pop_front()));
            end
            if (done) begin
                done_seen++;
                if (exp_done.size() == 0) flag("unexpected_done");
                else check("done_error", 72'(error), 72'(exp_done.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ctl"}, 72'({job_ready, busy, done, error, gen_valid, cmd_tvalid, sts_tready}),
              72'(7'b1000000));
        check({name, "_gen_length"}, 72'(gen_length), 72'd0);
        check({name, "_cmd_tdata"}, cmd_tdata, 72'd0);
    endtask

    // Drives one job and plays DataMover + generator for each burst.
    task automatic run_job(input logic [31:0] addr, input logic [25:0] beats, input int stall,
                           input int bad_burst, input int tlast_burst, input int tlast_beat,
                           input int reset_after);
        logic [25:0] lens[$];
        logic [31:0] addrs[$];
        logic [25:0] r, b;
        logic [31:0] a;
        logic [3:0]  tag_i;
        logic        exp_err;
        int stop, n, total, start_cmds, start_done;
        r = beats;
        a = addr;
        if (beats >= 26'd2) begin
            while (r != 26'd0) begin
                b = (r > 26'd257) ? 26'd256 : ((r == 26'd257) ? 26'd255 : r);
                lens.push_back(b);
                addrs.push_back(a);
                a = a + 32'(b * 16);
                r = r - b;
            end
        end
        stop = lens.size() - 1;
        if (bad_burst >= 0) stop = bad_burst;
        if (tlast_burst >= 0) stop = tlast_burst;
        exp_err = (beats < 26'd2) || (bad_burst >= 0) || (tlast_burst >= 0);
        for (int i = 0; i <= stop; i++) begin
            exp_cmd.push_back(make_cmd(lens[i], addrs[i], 4'(model_tag + 4'(i))));
            exp_gen.push_back(lens[i]);
        end
        if (reset_after < 0) exp_done.push_back(exp_err);
        start_cmds = cmd_seen;
        start_done = done_seen;

        job_valid = 1'b1;
        job_addr  = addr;
        job_beats = beats;
        n = 0;
        while (!job_ready && n < 20) begin tick(); n++; end
        if (!job_ready) begin flag("job_ready_timeout"); job_valid = 1'b0; return; end
        tick();
        job_valid = 1'b0;

        for (int i = 0; i <= stop; i++) begin
            tag_i = 4'(model_tag + 4'(i));
            n = 0;
            while (!cmd_tvalid && n < 50) begin tick(); n++; end
            if (!cmd_tvalid) begin flag("cmd_timeout"); return; end
            for (int s = 0; s < stall; s++) begin
                check("cmd_hold", cmd_tdata, make_cmd(lens[i], addrs[i], tag_i));
                tick();
            end
            cmd_tready = 1'b1;
            tick();
            cmd_tready = 1'b0;
            check("gen_pulse_on", 72'(gen_valid), 72'd1);
            tick();
            check("gen_pulse_off", 72'(gen_valid), 72'd0);
            check("gen_length_hold", 72'(gen_length), 72'(lens[i]));
            total = (i == tlast_burst) ? tlast_beat : int'(lens[i]);
            for (int k = 1; k <= total; k++) begin
                if (k % 7 == 0) begin
                    mon_tvalid = 1'b1; mon_tready = 1'b0; mon_tlast = 1'b0;
                    tick();
                end
                if (i == 0 && k == reset_after) begin
                    mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
                    axis_reset = 1'b1;
                    tick();
                    check_reset_outputs("mid_reset");
                    axis_reset = 1'b0;
                    model_tag = 4'd0;
                    repeat (3) tick();
                    check("no_done_after_reset", 72'(done_seen - start_done), 72'd0);
                    return;
                end
                mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = (k == total);
                tick();
            end
            mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
            sts_tdata  = (i == bad_burst) ? 8'h00 : {4'h8, tag_i};
            sts_tvalid = 1'b1;
            n = 0;
            while (!sts_tready && n < 20) begin tick(); n++; end
            if (!sts_tready) begin flag("sts_timeout"); sts_tvalid = 1'b0; return; end
            tick();
            sts_tvalid = 1'b0;
        end

        n = 0;
        while (!done && n < 20) begin tick(); n++; end
        if (!done) begin flag("done_timeout"); return; end
        tick();
        repeat (3) tick();
        check("cmd_count", 72'(cmd_seen - start_cmds), 72'(stop + 1));
        check("done_count", 72'(done_seen - start_done), 72'd1);
        check("idle_ready", 72'({job_ready, busy}), 72'(2'b10));
        if (stop > 0) model_tag = 4'(model_tag + 4'(stop));
    endtask

    initial begin
        axis_reset = 1'b1;
        job_valid  = 1'b0;
        job_addr   = '0;
        job_beats  = '0;
        mon_tvalid = 1'b0;
        mon_tready = 1'b0;
        mon_tlast  = 1'b0;
        cmd_tready = 1'b0;
        sts_tdata  = '0;
        sts_tvalid = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        axis_reset = 1'b0;
        tick();

        run_job(32'h1000_0000, 26'd600, 0, -1, -1, 0, -1);
        run_job(32'h2000_0000, 26'd257, 0, -1, -1, 0, -1);
        run_job(32'h0000_4000, 26'd1,   0, -1, -1, 0, -1);
        run_job(32'h0000_4000, 26'd0,   0, -1, -1, 0, -1);
        run_job(32'h3000_0000, 26'd8,  10, -1, -1, 0, -1);
        run_job(32'h4000_0000, 26'd600, 0,  0, -1, 0, -1);
        run_job(32'h5000_0000, 26'd256, 0, -1,  0, 100, -1);
        run_job(32'hFFFF_F000, 26'd512, 0, -1, -1, 0, -1);
        run_job(32'h6000_0000, 26'd256, 0, -1, -1, 0, 50);
        exp_cmd.delete();
        exp_gen.delete();
        run_job(32'h7000_0000, 26'd2,   0, -1, -1, 0, -1);

        check("left_cmd",  72'(exp_cmd.size()),  72'd0);
        check("left_gen",  72'(exp_gen.size()),  72'd0);
        check("left_done", 72'(exp_done.size()), 72'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", cmp_cnt);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/s2mm_write_scheduler.md
S2MM_WRITE_SCHEDULER -- requirements
Module: s2mm_write_scheduler

Interface
REQ-001 SHALL have parameter DW, default 128: stream data width in bits; bytes per beat BPB = DW/8.
REQ-002 SHALL have parameter MAX_BEATS, default 256: maximum beats per burst; legal range 4..2^22/BPB.
REQ-003 SHALL have parameter ADDR_W, default 32: byte address width.
REQ-004 SHALL have ports, one clock, synchronous active-high reset:
- axis_clk  in  1  sole clock, rising edge
- axis_reset  in  1  synchronous, active-high reset
- job_valid/job_ready  in/out  1/1  job handshake
- job_addr  in  ADDR_W  start byte address
- job_beats  in  26  total beats in the job
- gen_valid  out  1  one-cycle start pulse to the stream data generator
- gen_length  out  26  burst beat count for the generator
- mon_tvalid/mon_tready/mon_tlast  in  1/1/1  tap of the generator output stream
- cmd_tdata  out  72  DataMover S2MM command
- cmd_tvalid/cmd_tready  out/in  1/1  command handshake
- sts_tdata  in  8  DataMover status
- sts_tvalid/sts_tready  in/out  1/1  status handshake
- busy  out  1  job in progress
- done  out  1  one-cycle job-complete pulse
- error  out  1  sticky error flag; cleared on the next accepted job

Function
REQ-005 SHALL use FSM states IDLE, CMD, START, STREAM, STATUS, FINISH.
REQ-006 IDLE: job_ready=1; on job_valid, latch addr/beats and clear error.
- beats>=2 -> CMD.
- beats<2 -> FINISH with error=1 and no command issued.
REQ-007 Burst size from remaining beats R:
- R>MAX_BEATS+1 -> MAX_BEATS.
- R==MAX_BEATS+1 -> MAX_BEATS-1.
- else -> R.
- No burst is ever shorter than 2 beats.
REQ-008 CMD: cmd_tvalid=1 with cmd_tdata fields:
- [22:0] = burst*BPB
- [23] = 1 (INCR)
- [29:24] = 0
- [30] = 1 (EOF)
- [31] = 0
- [63:32] = current addr
- [67:64] = tag
- [71:68] = 0
- cmd_tdata SHALL hold stable while cmd_tvalid=1 and cmd_tready=0.
- On cmd_tvalid&cmd_tready -> START.
REQ-009 START: gen_valid=1 and gen_length=burst for exactly one cycle, then STREAM.
- gen_length SHALL hold its value until the next START.
REQ-010 STREAM: count beats where mon_tvalid&mon_tready. On a beat with mon_tlast=1 -> STATUS.
- tlast on beat count != burst -> error=1.
REQ-011 STATUS: sts_tready=1. On sts_tvalid, error is set if any of the following hold:
- sts_tdata[7]==0
- any of [6:4]==1
- [3:0] != issued tag
REQ-012 After a status, per outcome:
- error=1 -> FINISH; remaining bursts are abandoned.
- R-burst==0 -> FINISH.
- else addr += burst*BPB (wraps modulo 2^ADDR_W), R -= burst, tag += 1 (mod 16) -> CMD.
REQ-013 FINISH: done=1 for one cycle -> IDLE.
REQ-014 busy SHALL be 1 in every state except IDLE.
REQ-015 In IDLE, mon_* beats SHALL be ignored and sts_tready SHALL be 0.

Reset
REQ-016 On axis_reset=1 at a clock edge:
- state returns to IDLE.
- outputs: job_ready=1, busy=0, done=0, error=0, gen_valid=0, cmd_tvalid=0, sts_tready=0, gen_length=0, cmd_tdata=0.
- tag resets to 0; beat counter and remaining count reset to 0.
REQ-017 Reset mid-job SHALL discard the job without a done pulse; reset has priority over all other events in the same cycle.

Structure
REQ-018 A shared package SHALL hold:
- FSM state enum
- DataMover command bit positions (BTT, TYPE, EOF, SADDR, TAG)
- status bit positions (TAG, INTERR, DECERR, SLVERR, OKAY)
REQ-019 SHALL be a single module with no sub-modules; burst-size computation stays as inline combinational logic.

Verification
REQ-020 Bench coverage (DW=128, MAX_BEATS=256):
- Job addr=0x1000_0000, beats=600 -> three bursts:
  - 256 beats @0x1000_0000, BTT=4096, tag 0
  - 256 beats @0x1000_1000, tag 1
  - 88 beats @0x1000_2000, tag 2
  - then one done pulse, error=0.
- beats=257 -> bursts of 255 then 2; beats=1 -> done with error=1, cmd_tvalid never asserted.
- cmd_tready held 0 for 10 cycles -> cmd_tdata stable throughout; gen_valid pulses one cycle after acceptance.
- Status 0x00 (OKAY=0) on burst 1 of 3 -> error=1, done pulse, no second command.
- mon_tlast injected on beat 100 of a 256-beat burst -> error=1 after status; reset asserted in STREAM -> IDLE next cycle, no done, all outputs at reset values.
